pp_buf_ctrl: RTL

PP_BUF_CTRL -- requirements
Module: pp_buf_ctrl

---
 rtl/pp_buf_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pp_buf_ctrl.sv
// pp_buf_ctrl -- ping-pong line buffer controller.
//
// Incoming pixels fill two 2^AW x 8 banks alternately. Once a bank is full
// the read FSM emits a one-cycle start pulse, then streams the bank out at
// one byte per cycle on that bank's data/valid pair. A pixel that arrives
// while the bank it would go into is still full is dropped, and the sticky
// overflow flag is raised.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   din_valid, din[7:0]  input pixel stream
//   start                one-cycle pulse ahead of each block readout
//   ram0_valid_out/_data_out[7:0]  bank 0 readout
//   ram1_valid_out/_data_out[7:0]  bank 1 readout
//   overflow             sticky: an input pixel was dropped
module pp_buf_ctrl #(
  parameter int AW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_valid,
  input  logic [7:0] din,
  output logic       start,
  output logic       ram0_valid_out,
  output logic [7:0] ram0_data_out,
  output logic       ram1_valid_out,
  output logic [7:0] ram1_data_out,
  output logic       overflow
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2
  } rd_state_t;

  // Bank storage (not reset)
  logic [7:0]    r_mem0 [0:DEPTH-1];
  logic [7:0]    r_mem1 [0:DEPTH-1];

  // Write side
  logic          r_wr_sel;
  logic [AW-1:0] r_wr_addr;
  logic [1:0]    r_full;
  logic          r_overflow;

  // Read side
  rd_state_t     r_state;
  logic          r_rd_sel;
  logic [AW-1:0] r_rd_addr;
  logic          r_start;
  logic          r_valid0;
  logic          r_valid1;
  logic [7:0]    r_data0;
  logic [7:0]    r_data1;

  logic          w_wr_acc;
  logic          w_wr_drop;
  logic          w_wr_last;
  logic          w_rd_last;
  logic [1:0]    w_full_set;
  logic [1:0]    w_full_clr;

  always_comb begin
    w_wr_acc   = din_valid & ~r_full[r_wr_sel];
    w_wr_drop  = din_valid &  r_full[r_wr_sel];
    w_wr_last  = w_wr_acc & (r_wr_addr == '1);
    w_rd_last  = (r_state == READ) && (r_rd_addr == '1);
    w_full_set = '0;
    w_full_clr = '0;
    if (w_wr_last) w_full_set[r_wr_sel] = 1'b1;
    if (w_rd_last) w_full_clr[r_rd_sel] = 1'b1;
  end

  // Memory write port
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      if (r_wr_sel) r_mem1[r_wr_addr] <= din;
      else          r_mem0[r_wr_addr] <= din;
    end
  end

  // Write pointer, full flags, overflow.
  // Set and clear can land on the same edge only for different banks, so
  // both are applied independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_sel   <= 1'b0;
      r_wr_addr  <= '0;
      r_full     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_full <= (r_full & ~w_full_clr) | w_full_set;
      if (w_wr_acc) begin
        r_wr_addr <= r_wr_addr + AW'(1);
        if (w_wr_last) r_wr_sel <= ~r_wr_sel;
      end
      if (w_wr_drop) r_overflow <= 1'b1;
    end
  end

  // Read FSM with registered start/valid/data.
  // Read issued in cycle t is registered onto the selected bank's output in
  // cycle t+1; the last read returns while the FSM is already back in IDLE,
  // which guarantees a start pulse never overlaps a valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rd_sel  <= 1'b0;
      r_rd_addr <= '0;
      r_start   <= 1'b0;
      r_valid0  <= 1'b0;
      r_valid1  <= 1'b0;
      r_data0   <= '0;
      r_data1   <= '0;
    end else begin
      r_start  <= 1'b0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_full[r_rd_sel]) begin
            r_state <= START;
            r_start <= 1'b1;
          end
        end
        START: begin
          r_state   <= READ;
          r_rd_addr <= '0;
        end
        READ: begin
          if (r_rd_sel) begin
            r_data1  <= r_mem1[r_rd_addr];
            r_valid1 <= 1'b1;
          end else begin
            r_data0  <= r_mem0[r_rd_addr];
            r_valid0 <= 1'b1;
          end
          r_rd_addr <= r_rd_addr + AW'(1);
          if (w_rd_last) begin
            r_rd_sel <= ~r_rd_sel;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start          = r_start;
  assign ram0_valid_out = r_valid0;
  assign ram0_data_out  = r_data0;
  assign ram1_valid_out = r_valid1;
  assign ram1_data_out  = r_data1;
  assign overflow       = r_overflow;

endmodule
